// File: rtl/aes_kat_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_kat_sequencer
// Brief    : Feeds FIPS-197 AES-128/192/256 known-answer vectors to an external
//            encipher core and reports the pass/fail tally on status LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module aes_kat_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned NUM_VEC = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic         core_start,
  output logic [3:0]   core_nk,
  output logic [255:0] core_key,
  output logic [127:0] core_in,
  input  logic         core_done,
  input  logic [127:0] core_out,
  output logic         busy,
  output logic [1:0]   vec_idx,
  output logic [1:0]   err_count,
  output logic         led_pass,
  output logic         led_fail
);

  localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_tmax = CW'(TIMEOUT - 1);
  localparam logic [1:0]    c_last = 2'(NUM_VEC - 1);
  localparam logic [127:0]  c_pt   = 128'h00112233445566778899aabbccddeeff;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ISSUE = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_CHECK = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  function automatic logic [3:0] f_nk(input logic [1:0] idx);
    case (idx)
      2'd0:    f_nk = 4'd4;
      2'd1:    f_nk = 4'd6;
      2'd2:    f_nk = 4'd8;
      default: f_nk = 4'd0;
    endcase
  endfunction

  // Keys are MSB-aligned so the core always reads word 0 from bits [255:224].
  function automatic logic [255:0] f_key(input logic [1:0] idx);
    case (idx)
      2'd0:    f_key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      2'd1:    f_key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      2'd2:    f_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      default: f_key = 256'h0;
    endcase
  endfunction

  function automatic logic [127:0] f_ct(input logic [1:0] idx);
    case (idx)
      2'd0:    f_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'd1:    f_ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      2'd2:    f_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
      default: f_ct = 128'h0;
    endcase
  endfunction

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic          r_en_prev;
  logic          w_en_rise;
  logic          w_start_pass;
  logic [1:0]    w_issue_idx;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_ct;
  logic          r_timeout;
  logic          w_mismatch;
  logic [1:0]    r_vec_idx;
  logic [1:0]    r_err;
  logic [3:0]    r_nk;
  logic [255:0]  r_key;
  logic [127:0]  r_in;

  assign w_en_rise    = enable & ~r_en_prev;
  assign w_start_pass = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && w_en_rise;
  assign w_issue_idx  = w_start_pass ? 2'd0 : r_vec_idx + 2'd1;
  // A timeout leaves r_ct stale, so the forced flag must dominate the compare.
  assign w_mismatch   = r_timeout || (r_ct != f_ct(r_vec_idx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE,
      c_ST_DONE:  if (w_en_rise) w_next = c_ST_ISSUE;
      c_ST_ISSUE: w_next = c_ST_WAIT;
      c_ST_WAIT:  if (core_done || (r_cnt == c_tmax)) w_next = c_ST_CHECK;
      c_ST_CHECK: w_next = (r_vec_idx == c_last) ? c_ST_DONE : c_ST_ISSUE;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    core_start = 1'b0;
    busy       = 1'b0;
    led_pass   = 1'b0;
    led_fail   = 1'b0;
    case (r_state)
      c_ST_ISSUE: begin
        core_start = 1'b1;
        busy       = 1'b1;
      end
      c_ST_WAIT,
      c_ST_CHECK: busy = 1'b1;
      c_ST_DONE: begin
        led_pass = (r_err == 2'd0);
        led_fail = (r_err != 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_prev <= 1'b0;
      r_cnt     <= '0;
      r_ct      <= '0;
      r_timeout <= 1'b0;
      r_vec_idx <= 2'd0;
      r_err     <= 2'd0;
      r_nk      <= 4'd0;
      r_key     <= '0;
      r_in      <= '0;
    end else begin
      r_en_prev <= enable;
      if (w_start_pass) begin
        r_err <= 2'd0;
      end
      // Vector fields are loaded on entry to ISSUE and held until the next one.
      if (w_next == c_ST_ISSUE) begin
        r_vec_idx <= w_issue_idx;
        r_nk      <= f_nk(w_issue_idx);
        r_key     <= f_key(w_issue_idx);
        r_in      <= c_pt;
      end
      case (r_state)
        c_ST_ISSUE: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
        c_ST_WAIT: begin
          if (core_done) begin
            r_ct <= core_out;
          end else if (r_cnt == c_tmax) begin
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        c_ST_CHECK: begin
          if (w_mismatch && (r_err != 2'd3)) begin
            r_err <= r_err + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_nk   = r_nk;
  assign core_key  = r_key;
  assign core_in   = r_in;
  assign vec_idx   = r_vec_idx;
  assign err_count = r_err;

endmodule
`default_nettype wire
